// File: rtl/garage_door_plant.sv
// Behavioural garage door motor + limit-sensor model for closed-loop controller simulation.
// Optional feature macro OBSTRUCT_EN adds the Obstruct input and the one-cycle Obst_Hit output.
module garage_door_plant #(
    parameter int unsigned TRAVEL_TICKS  = 16,
    parameter int unsigned SPINUP_CYCLES = 2,
    parameter int unsigned POS_W         = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             DN_M,
`ifdef OBSTRUCT_EN
    input  logic             Obstruct,
    output logic             Obst_Hit,
`endif
    output logic             UP_Max,
    output logic             DN_Max,
    output logic [POS_W-1:0] Position,
    output logic             Moving,
    output logic             Fault
);

    typedef enum logic [2:0] {
        IDLE,
        SPINUP_UP,
        MOVING_UP,
        SPINUP_DN,
        MOVING_DN,
        FAULT
    } state_t;

    localparam bit               NO_SPINUP = (SPINUP_CYCLES == 0);
    localparam logic [POS_W-1:0] POS_TOP   = POS_W'(TRAVEL_TICKS);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPINUP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_START = NO_SPINUP ? CNT_W'(0) : CNT_ONE;
    localparam state_t           UP_START  = NO_SPINUP ? MOVING_UP : SPINUP_UP;
    localparam state_t           DN_START  = NO_SPINUP ? MOVING_DN : SPINUP_DN;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic               moving_q;
    logic               obst_c;
`ifdef OBSTRUCT_EN
    logic               obst_hit_q, obst_hit_d;
`endif

    // State, position, spin counter and sticky fault registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            moving_q <= (state_d == MOVING_UP) || (state_d == MOVING_DN);
        end
    end

`ifdef OBSTRUCT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            obst_hit_q <= 1'b0;
        end else begin
            obst_hit_q <= obst_hit_d;
        end
    end
`endif

    // Next-state logic: double command faults first, then obstruction, then normal travel
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
`ifdef OBSTRUCT_EN
        obst_hit_d = 1'b0;
        obst_c     = Obstruct;
`else
        obst_c     = 1'b0;
`endif

        if ((state_q != FAULT) && UP_M && DN_M) begin
            state_d = FAULT;
            fault_d = 1'b1;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (UP_M && (pos_q != POS_TOP)) begin
                        state_d = UP_START;
                        cnt_d   = CNT_START;
                    end else if (DN_M && (pos_q != '0) && !obst_c) begin
                        state_d = DN_START;
                        cnt_d   = CNT_START;
                    end
                end

                SPINUP_UP, MOVING_UP: begin
                    if (UP_M) begin
                        if (state_q == SPINUP_UP) begin
                            if (cnt_q == CNT_LAST) begin
                                state_d = MOVING_UP;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else if (pos_q >= POS_TOP) begin
                            state_d = IDLE;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                            if ((pos_q + POS_ONE) == POS_TOP) begin
                                state_d = IDLE;
                            end
                        end
                    end else if (DN_M) begin
                        state_d = DN_START;
                        cnt_d   = CNT_START;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end

                SPINUP_DN, MOVING_DN: begin
                    if (obst_c) begin
                        state_d = IDLE;
                        cnt_d   = '0;
`ifdef OBSTRUCT_EN
                        obst_hit_d = 1'b1;
`endif
                    end else if (DN_M) begin
                        if (state_q == SPINUP_DN) begin
                            if (cnt_q == CNT_LAST) begin
                                state_d = MOVING_DN;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else if (pos_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                            if (pos_q == POS_ONE) begin
                                state_d = IDLE;
                            end
                        end
                    end else if (UP_M) begin
                        state_d = UP_START;
                        cnt_d   = CNT_START;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end

                FAULT: begin
                    state_d = FAULT;
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Limit sensors decode the position register directly
    assign UP_Max   = (pos_q == POS_TOP);
    assign DN_Max   = (pos_q == '0);
    assign Position = pos_q;
    assign Moving   = moving_q;
    assign Fault    = fault_q;
`ifdef OBSTRUCT_EN
    assign Obst_Hit = obst_hit_q;
`endif

endmodule

// File: doc/garage_door_plant.md
Name: garage_door_plant

Overview:
Synthesizable behavioural model of the garage door mechanism, i.e. motor plus limit-sensor assembly, driven by the door controller. It consumes the controller's motor commands (UP_M, DN_M) and produces the limit-sensor signals (UP_Max, DN_Max) that the controller reads. It is used for closed-loop simulation and FPGA bring-up of the controller without real hardware. It models motor spin-up delay, finite travel time, limit stops and illegal-command faults.

Parameters:
TRAVEL_TICKS, 16, number of moving cycles from fully closed (0) to fully open; must be >= 2
SPINUP_CYCLES, 2, number of clock edges spent in spin-up before position starts to change; 0 = no spin-up
POS_W, 8, width of the position register; must hold TRAVEL_TICKS
CNT_W, 4, width of the spin-up counter; must hold SPINUP_CYCLES

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous, active-high reset
UP_M  input  1  open-motor command from controller
DN_M  input  1  close-motor command from controller
UP_Max  output  1  door fully open; decode of Position == TRAVEL_TICKS
DN_Max  output  1  door fully closed; decode of Position == 0
Position  output  POS_W  current door position; 0 = closed
Moving  output  1  high in MOVING_UP or MOVING_DN
Fault  output  1  sticky illegal-command flag

Behaviour:
- Reset: state IDLE, Position = 0, spin counter = 0, Fault = 0, Moving = 0, so DN_Max = 1 and UP_Max = 0. Reset takes effect immediately, including mid-motion.
- UP_Max and DN_Max are combinational decodes of the Position register. They are never both 1 because TRAVEL_TICKS >= 2.
- States: IDLE, SPINUP_UP, MOVING_UP, SPINUP_DN, MOVING_DN, FAULT.
- Any state except FAULT: if UP_M = 1 and DN_M = 1 are sampled together, go to FAULT. Set Fault = 1 and hold Position. FAULT exits only on RST.
- IDLE, UP_M = 1 and Position < TRAVEL_TICKS: go to MOVING_UP if SPINUP_CYCLES = 0, else go to SPINUP_UP with counter = 1. If the door is already fully open, stay IDLE. DN_M behaves symmetrically, blocked when Position = 0.
- SPINUP_x with its command still high: if counter == SPINUP_CYCLES, go to MOVING_x; otherwise increment the counter. Position does not change during spin-up.
- MOVING_UP with UP_M = 1: Position += 1 each edge. On the edge where Position becomes TRAVEL_TICKS, go to IDLE. MOVING_DN is symmetric, decrementing and stopping at 0. Position saturates and never wraps.
- Command dropped (in SPINUP_x or MOVING_x, own command = 0, other command = 0): go to IDLE on that edge. Position holds at the partial value. Counter clears.
- Reversal (own command = 0, opposite command = 1, same edge): go directly to SPINUP of the opposite direction, or to MOVING if SPINUP_CYCLES = 0. Counter restarts at 1 and Position holds on that edge.
- Latency: if UP_M is first sampled high at edge 1 from the closed position, UP_Max rises after edge 1 + SPINUP_CYCLES + TRAVEL_TICKS. With the defaults that is edge 19.
- Moving is registered with the state, so it is 0 in the cycle after the limit is reached.

Optional Feature:
OBSTRUCT_EN defined:
- Adds input Obstruct (1 bit) and output Obst_Hit (1 bit, reset 0).
- Obstruct = 1 sampled in SPINUP_DN or MOVING_DN: go to IDLE, hold Position, and pulse Obst_Hit high for exactly one cycle.
- While Obstruct = 1, IDLE refuses to start downward motion. Upward motion is unaffected.
- If the double-command fault condition also occurs on the same edge, the fault takes priority.

OBSTRUCT_EN undefined:
- Neither port exists and downward motion is never inhibited.

Test Plan:
- Reset held 2 cycles, then released with UP_M = DN_M = 0 -> Position = 0, DN_Max = 1, UP_Max = 0, Fault = 0, Moving = 0.
- Defaults, UP_M held from edge 1 -> Moving rises after edge 3, Position = 16 and UP_Max = 1 after edge 19, state IDLE. Then DN_M held -> DN_Max = 1 after 19 more edges.
- UP_M held 10 edges then dropped -> Position = 7 and holds, both limits 0. Then DN_M held -> Position reaches 0 after 1 + 2 + 7 edges.
- UP_M = DN_M = 1 on one edge mid-travel -> Fault = 1, Position frozen. Fault stays set after both commands clear, until RST clears it and sets Position to 0.
- RST asserted asynchronously mid-MOVING_UP (between edges) -> Position = 0 and DN_Max = 1 immediately, without waiting for an edge.
- OBSTRUCT_EN: open fully, hold DN_M, assert Obstruct at Position = 9 -> single-cycle Obst_Hit, Position holds 9. DN_M with Obstruct = 1 -> no motion. Obstruct low -> closing resumes after spin-up.
